cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Parametrised run-control unit for the CPU core.
- Replaces the fixed clock/mode controller with a clock-enable based mode FSM (RUN / PAUSE / STEP / ERROR / UART), debounced buttons, a maskable exception trap with latched code, a configurable-width cycle counter, and the soft-reset and UART-programming reset requests.
- Sits beside the CPU top; its outputs gate IFetch/ExeReg/DataMem and drive the uart_bmpg_0 reset.

Parameters:
- CNT_W, 32, width of cycle counter.
- EXC_W, 4, width of exception code.
- EXC_MASK, 16'hFFFE, bit k=1 means exception code k traps; bit 0 is ignored (code 0 = no exception).
- RST_EXC, 1, exception code that requests a soft CPU reset instead of trapping.
- ERR_MANUAL, 4'hF, code latched when btn_err is pressed.
- DEB_CYC, 20'd500000, cycles a button must be stable before it is accepted.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- btn_pause_i, btn_continue_i, btn_step_i, btn_err_i, btn_uart_i  in  1 each  raw asynchronous buttons
- exc_code_i  in  EXC_W  exception code from the execute stage; 0 = none
- set_cnt_i  in  1  clear cycle counter
- upg_done_i  in  1  UART programming finished
- cpu_en_o  out  1  CPU clock enable
- cpu_rst_o  out  1  soft reset to the pipeline
- upg_rst_o  out  1  UART programmer reset, active-high
- mode_o  out  4  current mode: RUN=0, PAUSE=1, STEP=2, ERROR=3, UART=6
- exc_latched_o  out  EXC_W  trapped exception code
- cycle_cnt_o  out  CNT_W  enabled-cycle count

Behaviour:
- Reset values:
  - mode_o=RUN, cpu_en_o=0, cpu_rst_o=1, upg_rst_o=1, exc_latched_o=0, cycle_cnt_o=0.
  - Debouncer state is cleared.
  - cpu_rst_o deasserts on the first cycle after reset_i falls. Reset mid-operation from any mode returns to these values.
- Buttons:
  - Each button passes through a 2-FF synchroniser, then a stability counter.
  - A level is accepted after DEB_CYC consecutive equal samples.
  - The accepted 0→1 transition produces a one-cycle pulse. Holding a button produces only one pulse.
- cpu_en_o is a registered output: 1 in RUN; 1 for exactly one cycle in STEP; 0 elsewhere. It is also 0 in any cycle where cpu_rst_o=1.
- Transition priority, highest first: btn_uart > exception > btn_err > continue/step/pause.
- RUN:
  - Trapping exception (exc_code_i≠0, EXC_MASK bit set, code≠RST_EXC) → ERROR, latch exc_code_i.
  - exc_code_i==RST_EXC → one-cycle cpu_rst_o pulse, stay RUN.
  - pause → PAUSE.
  - btn_err → ERROR, latch ERR_MANUAL.
  - uart → UART.
- PAUSE:
  - continue → RUN.
  - step → STEP.
  - btn_err → ERROR.
  - uart → UART.
  - Exceptions are ignored because the CPU is not enabled.
- STEP:
  - Lasts one cycle with cpu_en_o=1, then → PAUSE.
  - An exception sampled in that cycle → ERROR instead.
- ERROR:
  - CPU is held.
  - continue → exc_latched_o cleared, one-cycle cpu_rst_o, → RUN.
  - uart → UART.
  - Other buttons are ignored.
- UART:
  - upg_rst_o=0 from the cycle after entry.
  - upg_done_i → upg_rst_o=1, one-cycle cpu_rst_o, → RUN.
  - btn_err aborts: upg_rst_o=1, → ERROR with ERR_MANUAL.
  - upg_done_i and btn_err in the same cycle: done wins.
- Cycle counter:
  - Increments on every cycle where cpu_en_o=1.
  - Wraps modulo 2^CNT_W.
  - set_cnt_i clears it to 0 and wins over a simultaneous increment.
  - Also cleared by cpu_rst_o.
- Masked exception codes (mask bit 0) are ignored in all modes.

Decomposition:
- Shared package:
  - mode encodings MODE_RUN/PAUSE/STEP/ERROR/UART.
  - mode_t typedef of 4 bits.
  - ERR_MANUAL default.
- One natural sub-module: btn_debounce (parameter DEB_CYC; ports clk_i, reset_i, btn_i, pulse_o), instantiated five times.

Test Plan (DEB_CYC=4, CNT_W=8):
- Reset, then idle 10 cycles → mode_o=0, cpu_en_o=1 from cycle 2, cycle_cnt_o=9.
- Pause button held 3 cycles (bounce) → no transition. Held 6 cycles → mode_o=1, cpu_en_o=0, counter frozen. Step → exactly one cpu_en_o cycle, count+1, mode_o back to 1.
- exc_code_i=4'd5 in RUN → mode_o=3, exc_latched_o=5, cpu_en_o=0. Continue → cpu_rst_o 1-cycle pulse, exc_latched_o=0, mode_o=0, counter=0.
- exc_code_i=1 in RUN → cpu_rst_o pulse, mode stays 0. With EXC_MASK bit 5 cleared, exc_code_i=5 → no trap.
- Counter at 8'hFF plus an enabled cycle → 8'h00. set_cnt_i together with enable → 0.
- btn_uart → mode_o=6, upg_rst_o=0. upg_done_i together with btn_err pulse → upg_rst_o=1, cpu_rst_o pulse, mode_o=0.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_run_ctrl_pkg
// Mode encodings, button indices and defaults shared by the run-control unit.
// Rev     : 1.0
// ============================================================================
package cpu_run_ctrl_pkg;

    typedef logic [3:0] mode_t;

    localparam mode_t MODE_RUN   = 4'd0;
    localparam mode_t MODE_PAUSE = 4'd1;
    localparam mode_t MODE_STEP  = 4'd2;
    localparam mode_t MODE_ERROR = 4'd3;
    localparam mode_t MODE_UART  = 4'd6;

    localparam logic [3:0] ERR_MANUAL_DEF = 4'hF;

    // Bit positions of the buttons in the packed debounce vector
    localparam int c_BTN_PAUSE = 0;
    localparam int c_BTN_CONT  = 1;
    localparam int c_BTN_STEP  = 2;
    localparam int c_BTN_ERR   = 3;
    localparam int c_BTN_UART  = 4;
    localparam int c_BTN_N     = 5;

endpackage
`default_nettype wire

// File: rtl/cpu_run_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module : btn_debounce
// Synchronises a raw button, accepts a level after DEB_CYC stable samples and
// emits a single-cycle pulse on each accepted press.
// Rev    : 1.0
// ============================================================================
module btn_debounce #(
    parameter int unsigned DEB_CYC = 500000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned        c_CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEB_CYC - 1);

    logic [1:0]         r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_stable;
    logic               r_pulse;
    logic               w_diff;
    logic               w_accept;

    // r_cnt counts consecutive samples that disagree with the accepted level
    assign w_diff   = r_sync[1] ^ r_stable;
    assign w_accept = w_diff && (r_cnt == c_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sync   <= 2'b00;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_i};
            r_pulse <= w_accept & r_sync[1];
            if (w_accept) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pulse_o = r_pulse;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module : cpu_run_ctrl
// CPU run control: mode FSM driving the core clock enable and soft resets,
// debounced buttons, maskable exception trap and enabled-cycle counter.
// Rev    : 1.0
// ============================================================================
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned             CNT_W      = 32,
    parameter int unsigned             EXC_W      = 4,
    parameter logic [(2**EXC_W)-1:0]   EXC_MASK   = 16'hFFFE,
    parameter logic [EXC_W-1:0]        RST_EXC    = EXC_W'(1),
    parameter logic [EXC_W-1:0]        ERR_MANUAL = EXC_W'(ERR_MANUAL_DEF),
    parameter int unsigned             DEB_CYC    = 500000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             btn_pause_i,
    input  logic             btn_continue_i,
    input  logic             btn_step_i,
    input  logic             btn_err_i,
    input  logic             btn_uart_i,
    input  logic [EXC_W-1:0] exc_code_i,
    input  logic             set_cnt_i,
    input  logic             upg_done_i,
    output logic             cpu_en_o,
    output logic             cpu_rst_o,
    output logic             upg_rst_o,
    output logic [3:0]       mode_o,
    output logic [EXC_W-1:0] exc_latched_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    logic [c_BTN_N-1:0] w_btn_raw;
    logic [c_BTN_N-1:0] w_btn_pulse;

    logic w_pause;
    logic w_cont;
    logic w_step;
    logic w_err;
    logic w_uart;
    logic w_trap;
    logic w_rst_req;

    mode_t            r_mode;
    logic             r_cpu_en;
    logic             r_cpu_rst;
    logic             r_upg_rst;
    logic [EXC_W-1:0] r_exc;
    logic [CNT_W-1:0] r_cnt;

    assign w_btn_raw = {btn_uart_i, btn_err_i, btn_step_i, btn_continue_i, btn_pause_i};

    for (genvar i = 0; i < c_BTN_N; i++) begin : g_btn
        btn_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .btn_i   (w_btn_raw[i]),
            .pulse_o (w_btn_pulse[i])
        );
    end

    assign w_pause = w_btn_pulse[c_BTN_PAUSE];
    assign w_cont  = w_btn_pulse[c_BTN_CONT];
    assign w_step  = w_btn_pulse[c_BTN_STEP];
    assign w_err   = w_btn_pulse[c_BTN_ERR];
    assign w_uart  = w_btn_pulse[c_BTN_UART];

    // Code 0 means "no exception"; the soft-reset code never traps
    assign w_trap    = (exc_code_i != '0) && EXC_MASK[exc_code_i] && (exc_code_i != RST_EXC);
    assign w_rst_req = (exc_code_i == RST_EXC) && EXC_MASK[RST_EXC];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_mode    <= MODE_RUN;
            r_cpu_en  <= 1'b0;
            r_cpu_rst <= 1'b1;
            r_upg_rst <= 1'b1;
            r_exc     <= '0;
        end else begin
            r_cpu_en  <= 1'b0;
            r_cpu_rst <= 1'b0;
            case (r_mode)
                MODE_RUN: begin
                    if (w_uart) begin
                        r_mode <= MODE_UART;
                    end else if (w_trap) begin
                        r_mode <= MODE_ERROR;
                        r_exc  <= exc_code_i;
                    end else if (w_rst_req) begin
                        r_cpu_rst <= 1'b1;
                    end else if (w_err) begin
                        r_mode <= MODE_ERROR;
                        r_exc  <= ERR_MANUAL;
                    end else if (w_pause) begin
                        r_mode <= MODE_PAUSE;
                    end else begin
                        r_cpu_en <= 1'b1;
                    end
                end
                MODE_PAUSE: begin
                    if (w_uart) begin
                        r_mode <= MODE_UART;
                    end else if (w_err) begin
                        r_mode <= MODE_ERROR;
                        r_exc  <= ERR_MANUAL;
                    end else if (w_cont) begin
                        r_mode   <= MODE_RUN;
                        r_cpu_en <= 1'b1;
                    end else if (w_step) begin
                        r_mode   <= MODE_STEP;
                        r_cpu_en <= 1'b1;
                    end
                end
                MODE_STEP: begin
                    // The single enabled cycle is the one spent in this state
                    if (w_uart) begin
                        r_mode <= MODE_UART;
                    end else if (w_trap) begin
                        r_mode <= MODE_ERROR;
                        r_exc  <= exc_code_i;
                    end else if (w_rst_req) begin
                        r_mode    <= MODE_PAUSE;
                        r_cpu_rst <= 1'b1;
                    end else if (w_err) begin
                        r_mode <= MODE_ERROR;
                        r_exc  <= ERR_MANUAL;
                    end else begin
                        r_mode <= MODE_PAUSE;
                    end
                end
                MODE_ERROR: begin
                    if (w_uart) begin
                        r_mode <= MODE_UART;
                    end else if (w_cont) begin
                        r_mode    <= MODE_RUN;
                        r_exc     <= '0;
                        r_cpu_rst <= 1'b1;
                    end
                end
                MODE_UART: begin
                    if (upg_done_i) begin
                        r_mode    <= MODE_RUN;
                        r_upg_rst <= 1'b1;
                        r_cpu_rst <= 1'b1;
                    end else if (w_err) begin
                        r_mode    <= MODE_ERROR;
                        r_upg_rst <= 1'b1;
                        r_exc     <= ERR_MANUAL;
                    end else begin
                        r_upg_rst <= 1'b0;
                    end
                end
                default: begin
                    r_mode    <= MODE_RUN;
                    r_cpu_rst <= 1'b1;
                    r_upg_rst <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || r_cpu_rst || set_cnt_i) begin
            r_cnt <= '0;
        end else if (r_cpu_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cpu_en_o      = r_cpu_en;
    assign cpu_rst_o     = r_cpu_rst;
    assign upg_rst_o     = r_upg_rst;
    assign mode_o        = r_mode;
    assign exc_latched_o = r_exc;
    assign cycle_cnt_o   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_run_ctrl
// Scoreboard bench: a mode-level reference model predicts both instances
// (default mask and mask with bit 5 cleared) every cycle; a monitor compares.
// Rev    : 1.0
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int         c_DEB   = 4;
    localparam logic [3:0] M_RUN   = 4'd0;
    localparam logic [3:0] M_PAUSE = 4'd1;
    localparam logic [3:0] M_STEP  = 4'd2;
    localparam logic [3:0] M_ERROR = 4'd3;
    localparam logic [3:0] M_UART  = 4'd6;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;   // {uart, err, step, continue, pause}
    logic [3:0] exc;
    logic       set_cnt;
    logic       upg_done;

    logic       a_en, a_rst, a_upg, b_en, b_rst, b_upg;
    logic [3:0] a_mode, a_exc, b_mode, b_exc;
    logic [7:0] a_cnt, b_cnt;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.CNT_W(8), .EXC_W(4), .EXC_MASK(16'hFFFE), .RST_EXC(4'd1),
                   .ERR_MANUAL(4'hF), .DEB_CYC(c_DEB)) dut_a (
        .clk_i(clk), .reset_i(rst),
        .btn_pause_i(btn[0]), .btn_continue_i(btn[1]), .btn_step_i(btn[2]),
        .btn_err_i(btn[3]), .btn_uart_i(btn[4]),
        .exc_code_i(exc), .set_cnt_i(set_cnt), .upg_done_i(upg_done),
        .cpu_en_o(a_en), .cpu_rst_o(a_rst), .upg_rst_o(a_upg),
        .mode_o(a_mode), .exc_latched_o(a_exc), .cycle_cnt_o(a_cnt));

    cpu_run_ctrl #(.CNT_W(8), .EXC_W(4), .EXC_MASK(16'hFFDE), .RST_EXC(4'd1),
                   .ERR_MANUAL(4'hF), .DEB_CYC(c_DEB)) dut_b (
        .clk_i(clk), .reset_i(rst),
        .btn_pause_i(btn[0]), .btn_continue_i(btn[1]), .btn_step_i(btn[2]),
        .btn_err_i(btn[3]), .btn_uart_i(btn[4]),
        .exc_code_i(exc), .set_cnt_i(set_cnt), .upg_done_i(upg_done),
        .cpu_en_o(b_en), .cpu_rst_o(b_rst), .upg_rst_o(b_upg),
        .mode_o(b_mode), .exc_latched_o(b_exc), .cycle_cnt_o(b_cnt));

    typedef struct packed {
        logic [3:0] mode;
        logic       en;
        logic       rst;
        logic       upg;
        logic [3:0] exc;
        logic [7:0] cnt;
    } mst_t;

    typedef struct {
        int   cyc;
        mst_t a;
        mst_t b;
    } exp_t;

    exp_t sb[$];
    mst_t ma, mb;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   hold [5];

    // Button model: raw -> two-edge delay -> accept after c_DEB equal samples
    logic [4:0] d_p0, d_p1, d_acc, d_pulse, d_last;
    int         d_run [5];

    function automatic mst_t reset_state();
        mst_t s;
        s.mode = M_RUN; s.en = 1'b0; s.rst = 1'b1; s.upg = 1'b1;
        s.exc  = 4'd0;  s.cnt = 8'd0;
        return s;
    endfunction

    function automatic mst_t fsm_step(input mst_t s, input logic [4:0] pl, input logic [3:0] code,
                                      input logic set, input logic done, input logic [15:0] mask);
        mst_t n;
        logic trap, rreq;
        n     = s;
        n.rst = 1'b0;
        trap  = (code != 4'd0) && mask[code] && (code != 4'd1);
        rreq  = (code == 4'd1) && mask[1];
        n.cnt = (s.rst || set) ? 8'd0 : (s.en ? s.cnt + 8'd1 : s.cnt);
        case (s.mode)
            M_RUN: begin
                if (pl[4])      n.mode = M_UART;
                else if (trap)  begin n.mode = M_ERROR; n.exc = code; end
                else if (rreq)  n.rst = 1'b1;
                else if (pl[3]) begin n.mode = M_ERROR; n.exc = 4'hF; end
                else if (pl[0]) n.mode = M_PAUSE;
            end
            M_PAUSE: begin
                if (pl[4])      n.mode = M_UART;
                else if (pl[3]) begin n.mode = M_ERROR; n.exc = 4'hF; end
                else if (pl[1]) n.mode = M_RUN;
                else if (pl[2]) n.mode = M_STEP;
            end
            M_STEP: begin
                if (pl[4])      n.mode = M_UART;
                else if (trap)  begin n.mode = M_ERROR; n.exc = code; end
                else begin
                    n.mode = M_PAUSE;
                    if (rreq)       n.rst = 1'b1;
                    else if (pl[3]) begin n.mode = M_ERROR; n.exc = 4'hF; end
                end
            end
            M_ERROR: begin
                if (pl[4])      n.mode = M_UART;
                else if (pl[1]) begin n.mode = M_RUN; n.exc = 4'd0; n.rst = 1'b1; end
            end
            M_UART: begin
                if (done)       begin n.mode = M_RUN; n.rst = 1'b1; end
                else if (pl[3]) begin n.mode = M_ERROR; n.exc = 4'hF; end
            end
            default: ;
        endcase
        // The core runs in RUN and for the one STEP cycle, never during a soft reset
        n.en  = ((n.mode == M_RUN) || (n.mode == M_STEP)) && !n.rst;
        n.upg = !((s.mode == M_UART) && (n.mode == M_UART));
        return n;
    endfunction

    task automatic model_edge();
        logic [4:0] synced;
        exp_t       e;
        cyc++;
        if (rst) begin
            ma = reset_state();
            mb = reset_state();
            d_p0 = '0; d_p1 = '0; d_acc = '0; d_pulse = '0; d_last = '0;
            for (int i = 0; i < 5; i++) d_run[i] = 0;
        end else begin
            ma = fsm_step(ma, d_pulse, exc, set_cnt, upg_done, 16'hFFFE);
            mb = fsm_step(mb, d_pulse, exc, set_cnt, upg_done, 16'hFFDE);
            synced = d_p1;
            for (int i = 0; i < 5; i++) begin
                d_run[i]   = (d_run[i] > 0 && synced[i] == d_last[i]) ? d_run[i] + 1 : 1;
                d_last[i]  = synced[i];
                d_pulse[i] = (d_run[i] >= c_DEB) && (synced[i] != d_acc[i]) && synced[i];
                if (d_run[i] >= c_DEB) d_acc[i] = synced[i];
            end
            d_p1 = d_p0;
            d_p0 = btn;
        end
        e.cyc = cyc; e.a = ma; e.b = mb;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int b, input int len);
        btn[b] = 1'b1;
        idle(len);
        btn[b] = 1'b0;
    endtask

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    // Monitor: every cycle the outputs of both instances are a presented response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("a_mode", e.cyc, 32'(a_mode), 32'(e.a.mode));
                check("a_cpu_en", e.cyc, 32'(a_en), 32'(e.a.en));
                check("a_cpu_rst", e.cyc, 32'(a_rst), 32'(e.a.rst));
                check("a_upg_rst", e.cyc, 32'(a_upg), 32'(e.a.upg));
                check("a_exc_latched", e.cyc, 32'(a_exc), 32'(e.a.exc));
                check("a_cycle_cnt", e.cyc, 32'(a_cnt), 32'(e.a.cnt));
                check("b_mode", e.cyc, 32'(b_mode), 32'(e.b.mode));
                check("b_cpu_en", e.cyc, 32'(b_en), 32'(e.b.en));
                check("b_cpu_rst", e.cyc, 32'(b_rst), 32'(e.b.rst));
                check("b_upg_rst", e.cyc, 32'(b_upg), 32'(e.b.upg));
                check("b_exc_latched", e.cyc, 32'(b_exc), 32'(e.b.exc));
                check("b_cycle_cnt", e.cyc, 32'(b_cnt), 32'(e.b.cnt));
            end
        end
    end

    initial begin
        rst = 1'b1; btn = '0; exc = 4'd0; set_cnt = 1'b0; upg_done = 1'b0;
        for (int i = 0; i < 5; i++) hold[i] = 0;
        ma = reset_state(); mb = reset_state();
        d_p0 = '0; d_p1 = '0; d_acc = '0; d_pulse = '0; d_last = '0;
        for (int i = 0; i < 5; i++) d_run[i] = 0;

        idle(3);
        rst = 1'b0;
        idle(10);

        press(0, 3); idle(8);          // bounce: too short to be accepted
        press(0, 6); idle(8);          // pause
        press(2, 6); idle(8);          // single step
        press(1, 6); idle(8);          // continue

        exc = 4'd5; tick(); exc = 4'd0; idle(3);
        press(1, 6); idle(8);          // leave ERROR on instance a
        exc = 4'd1; tick(); exc = 4'd0; idle(4);

        idle(150);
        set_cnt = 1'b1; tick(); set_cnt = 1'b0;
        idle(270);                     // counter wraps through 8'hFF
        set_cnt = 1'b1; tick(); set_cnt = 1'b0;
        idle(5);

        press(4, 6); idle(8);          // enter UART
        btn[3] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            upg_done = d_pulse[3];     // done arrives together with the err pulse
            tick();
        end
        btn[3] = 1'b0; upg_done = 1'b0;
        idle(8);

        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < 5; i++) begin
                if (hold[i] > 0) begin
                    btn[i] = 1'b1;
                    hold[i]--;
                end else begin
                    btn[i] = 1'b0;
                    if ($urandom_range(0, 39) == 0) hold[i] = $urandom_range(1, 9);
                end
            end
            exc      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            set_cnt  = ($urandom_range(0, 29) == 0);
            upg_done = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end

        rst = 1'b0; btn = '0; exc = 4'd0; set_cnt = 1'b0; upg_done = 1'b0;
        idle(12);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
